// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between the fetch and MEM-stage data requesters.
// The grant is locked until the address is accepted; an in-order ID FIFO routes each response back.
module mem_port_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  outstanding_cnt,
    output logic        proto_err,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a requester holds req and payload stable until its addr_ok;
    // a transfer is accepted in any cycle where mem_req && mem_addr_ok.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_e;

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTSTANDING - 1);
    localparam logic [2:0] FULL_CNT = 3'(OUTSTANDING);

    state_e                  state_q, state_d;
    logic [OUTSTANDING-1:0]  ids_q;
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [2:0]              cnt_q, cnt_d;
    logic                    proto_err_q, proto_err_d;

    logic sel_inst, sel_data;
    logic full, empty, push, pop, head_id;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == 3'd0);

    // Registered full gates new grants, so a pop while full costs one bubble.
    always_comb begin
        sel_inst = 1'b0;
        sel_data = 1'b0;
        if (resetn) begin
            case (state_q)
                IDLE: begin
                    if (!full) begin
                        if (data_req)      sel_data = 1'b1;
                        else if (inst_req) sel_inst = 1'b1;
                    end
                end
                LOCK_I:  sel_inst = 1'b1;
                LOCK_D:  sel_data = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd2;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        if (sel_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end else if (sel_inst) begin
            mem_addr  = inst_addr;
        end
    end

    assign mem_req      = sel_inst | sel_data;
    assign push         = mem_req & mem_addr_ok;
    assign inst_addr_ok = push & sel_inst;
    assign data_addr_ok = push & sel_data;

    assign head_id      = ids_q[rd_ptr_q];
    assign pop          = resetn & mem_data_ok & ~empty;
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop & head_id;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_req && !mem_addr_ok) state_d = sel_data ? LOCK_D : LOCK_I;
            end
            LOCK_I, LOCK_D: begin
                if (mem_addr_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    assign proto_err_d = proto_err_q | (mem_data_ok & empty);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            ids_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= 3'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
            if (push) begin
                ids_q[wr_ptr_q] <= sel_data;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
        end
    end

    assign outstanding_cnt = cnt_q;
    assign proto_err       = proto_err_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a cycle table of directed corner cases, then random
// traffic checked against an owner-ID scoreboard.
module tb_mem_port_arbiter;

    localparam int OUT = 2;

    logic        clk, resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic [2:0]  outstanding_cnt;
    logic        proto_err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [0:0] exp_q[$];

    mem_port_arbiter #(.OUTSTANDING(OUT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding_cnt(outstanding_cnt), .proto_err(proto_err), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst_n, ireq, dreq, dwr, aok, dok;
        logic [31:0] rdata;
        logic        e_req, e_wr;
        logic [31:0] e_addr;
        logic        e_iaok, e_daok, e_idok, e_ddok;
        logic [2:0]  e_cnt;
        logic        e_perr;
        logic [1:0]  e_st;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs[NV];

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        resetn      = v.rst_n;
        inst_req    = v.ireq;
        inst_addr   = 32'h1C00_0000;
        data_req    = v.dreq;
        data_wr     = v.dwr;
        data_size   = 2'd1;
        data_addr   = 32'h0000_1000;
        data_wstrb  = v.dwr ? 4'b0011 : 4'b0000;
        data_wdata  = v.dwr ? 32'hABCD_1234 : 32'd0;
        mem_addr_ok = v.aok;
        mem_data_ok = v.dok;
        mem_rdata   = v.rdata;
        #2;
        chk($sformatf("v%0d mem_req", idx), 32'(mem_req), 32'(v.e_req));
        chk($sformatf("v%0d inst_addr_ok", idx), 32'(inst_addr_ok), 32'(v.e_iaok));
        chk($sformatf("v%0d data_addr_ok", idx), 32'(data_addr_ok), 32'(v.e_daok));
        chk($sformatf("v%0d inst_data_ok", idx), 32'(inst_data_ok), 32'(v.e_idok));
        chk($sformatf("v%0d data_data_ok", idx), 32'(data_data_ok), 32'(v.e_ddok));
        chk($sformatf("v%0d cnt", idx), 32'(outstanding_cnt), 32'(v.e_cnt));
        chk($sformatf("v%0d proto_err", idx), 32'(proto_err), 32'(v.e_perr));
        chk($sformatf("v%0d state", idx), 32'(dbg_state), 32'(v.e_st));
        if (v.e_req) begin
            chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_addr);
            chk($sformatf("v%0d mem_wr", idx), 32'(mem_wr), 32'(v.e_wr));
            chk($sformatf("v%0d mem_wstrb", idx), 32'(mem_wstrb), v.e_wr ? 32'h3 : 32'h0);
            chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wr ? 32'hABCD_1234 : 32'h0);
            chk($sformatf("v%0d mem_size", idx), 32'(mem_size),
                (v.e_addr == 32'h1000) ? 32'd1 : 32'd2);
        end
        if (v.dok) begin
            chk($sformatf("v%0d inst_rdata", idx), inst_rdata, v.rdata);
            chk($sformatf("v%0d data_rdata", idx), data_rdata, v.rdata);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b0;
        @(negedge clk);
        #2;
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst data_addr_ok", 32'(data_addr_ok), 32'd0);
        chk("rst cnt", 32'(outstanding_cnt), 32'd0);
        chk("rst proto_err", 32'(proto_err), 32'd0);
        chk("rst state", 32'(dbg_state), 32'd0);
        exp_q.delete();
    endtask

    task automatic random_phase(input int cycles);
        logic        i_pend, d_pend, si, sd, full, head;
        logic [31:0] i_addr, d_addr, d_wdata, e_addr, e_wdata;
        logic        d_wr, e_wr;
        logic [1:0]  d_size, e_size, m_st;
        logic [3:0]  d_wstrb, e_wstrb;
        i_pend = 1'b0; d_pend = 1'b0; m_st = 2'd0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_wr = 1'b0; d_size = 2'd0; d_wstrb = 4'd0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            resetn = 1'b1;
            if (!i_pend && $urandom_range(0, 1) == 1) begin
                i_pend = 1'b1;
                i_addr = {$urandom, 2'b00} ;
            end
            if (!d_pend && $urandom_range(0, 1) == 1) begin
                d_pend  = 1'b1;
                d_wr    = 1'($urandom_range(0, 1));
                d_size  = 2'($urandom_range(0, 2));
                d_addr  = $urandom;
                d_wstrb = 4'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            inst_req = i_pend; inst_addr = i_addr;
            data_req = d_pend; data_wr = d_wr; data_size = d_size; data_addr = d_addr;
            data_wstrb = d_wstrb; data_wdata = d_wdata;
            mem_addr_ok = ($urandom_range(0, 9) < 6);
            mem_data_ok = (exp_q.size() > 0) && ($urandom_range(0, 9) < 4);
            mem_rdata   = $urandom;

            full = (exp_q.size() == OUT);
            si = 1'b0; sd = 1'b0;
            if (m_st == 2'd0) begin
                if (!full && d_pend)      sd = 1'b1;
                else if (!full && i_pend) si = 1'b1;
            end else if (m_st == 2'd1) si = 1'b1;
            else sd = 1'b1;
            e_addr = sd ? d_addr : (si ? i_addr : 32'd0);
            e_wr = sd & d_wr;
            e_size = sd ? d_size : 2'd2;
            e_wstrb = sd ? d_wstrb : 4'd0;
            e_wdata = sd ? d_wdata : 32'd0;

            #2;
            chk("rnd mem_req", 32'(mem_req), 32'(si | sd));
            chk("rnd inst_addr_ok", 32'(inst_addr_ok), 32'(si & mem_addr_ok));
            chk("rnd data_addr_ok", 32'(data_addr_ok), 32'(sd & mem_addr_ok));
            chk("rnd cnt", 32'(outstanding_cnt), 32'(exp_q.size()));
            chk("rnd state", 32'(dbg_state), 32'(m_st));
            chk("rnd proto_err", 32'(proto_err), 32'd0);
            if (si | sd) begin
                chk("rnd mem_addr", mem_addr, e_addr);
                chk("rnd mem_wr", 32'(mem_wr), 32'(e_wr));
                chk("rnd mem_size", 32'(mem_size), 32'(e_size));
                chk("rnd mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
                chk("rnd mem_wdata", mem_wdata, e_wdata);
            end
            if (mem_data_ok) begin
                head = exp_q.pop_front();
                chk("rnd inst_data_ok", 32'(inst_data_ok), 32'(!head));
                chk("rnd data_data_ok", 32'(data_data_ok), 32'(head));
                chk("rnd rdata", head ? data_rdata : inst_rdata, mem_rdata);
            end else begin
                chk("rnd no data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
            end
            if ((si | sd) && mem_addr_ok) exp_q.push_back(sd);

            if (m_st == 2'd0) begin
                if ((si | sd) && !mem_addr_ok) m_st = sd ? 2'd2 : 2'd1;
            end else if (mem_addr_ok) m_st = 2'd0;
            if (si && mem_addr_ok) i_pend = 1'b0;
            if (sd && mem_addr_ok) d_pend = 1'b0;
        end
    endtask

    initial begin
        resetn = 1'b0; inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0;
        data_wstrb = 4'd0; data_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;

        //          rst ireq dreq dwr aok dok rdata         req wr addr           iaok daok idok ddok cnt perr st
        vecs[0]  = '{1, 1, 0, 0, 1, 0, 32'h0,         1, 0, 32'h1C00_0000, 1, 0, 0, 0, 3'd0, 0, 2'd0};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd1, 0, 2'd0};
        vecs[2]  = '{1, 0, 0, 0, 0, 1, 32'h0280_0000, 0, 0, 32'h0,         0, 0, 1, 0, 3'd1, 0, 2'd0};
        vecs[3]  = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0, 2'd0};
        vecs[4]  = '{1, 1, 1, 1, 1, 0, 32'h0,         1, 1, 32'h0000_1000, 0, 1, 0, 0, 3'd0, 0, 2'd0};
        vecs[5]  = '{1, 1, 0, 0, 1, 0, 32'h0,         1, 0, 32'h1C00_0000, 1, 0, 0, 0, 3'd1, 0, 2'd0};
        vecs[6]  = '{1, 0, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 32'h0,         0, 0, 0, 1, 3'd2, 0, 2'd0};
        vecs[7]  = '{1, 0, 0, 0, 0, 1, 32'h2222_2222, 0, 0, 32'h0,         0, 0, 1, 0, 3'd1, 0, 2'd0};
        vecs[8]  = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0, 2'd0};
        vecs[9]  = '{1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 32'h1C00_0000, 0, 0, 0, 0, 3'd0, 0, 2'd0};
        vecs[10] = '{1, 1, 1, 0, 0, 0, 32'h0,         1, 0, 32'h1C00_0000, 0, 0, 0, 0, 3'd0, 0, 2'd1};
        vecs[11] = '{1, 1, 1, 0, 0, 0, 32'h0,         1, 0, 32'h1C00_0000, 0, 0, 0, 0, 3'd0, 0, 2'd1};
        vecs[12] = '{1, 1, 1, 0, 1, 0, 32'h0,         1, 0, 32'h1C00_0000, 1, 0, 0, 0, 3'd0, 0, 2'd1};
        vecs[13] = '{1, 0, 1, 0, 1, 0, 32'h0,         1, 0, 32'h0000_1000, 0, 1, 0, 0, 3'd1, 0, 2'd0};
        vecs[14] = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd2, 0, 2'd0};
        vecs[15] = '{1, 0, 1, 0, 1, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd2, 0, 2'd0};
        vecs[16] = '{1, 0, 1, 0, 1, 1, 32'h3333_3333, 0, 0, 32'h0,         0, 0, 1, 0, 3'd2, 0, 2'd0};
        vecs[17] = '{1, 0, 1, 0, 1, 1, 32'h4444_4444, 1, 0, 32'h0000_1000, 0, 1, 0, 1, 3'd1, 0, 2'd0};
        vecs[18] = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd1, 0, 2'd0};
        vecs[19] = '{1, 0, 0, 0, 0, 1, 32'h5555_5555, 0, 0, 32'h0,         0, 0, 0, 1, 3'd1, 0, 2'd0};
        vecs[20] = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0, 2'd0};
        vecs[21] = '{1, 1, 0, 0, 1, 0, 32'h0,         1, 0, 32'h1C00_0000, 1, 0, 0, 0, 3'd0, 0, 2'd0};
        vecs[22] = '{1, 0, 1, 0, 1, 0, 32'h0,         1, 0, 32'h0000_1000, 0, 1, 0, 0, 3'd1, 0, 2'd0};
        vecs[23] = '{0, 1, 0, 0, 1, 1, 32'h6666_6666, 0, 0, 32'h0,         0, 0, 0, 0, 3'd2, 0, 2'd0};
        vecs[24] = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0, 2'd0};
        vecs[25] = '{1, 0, 0, 0, 0, 1, 32'h7777_7777, 0, 0, 32'h0,         0, 0, 0, 0, 3'd0, 0, 2'd0};
        vecs[26] = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd0, 1, 2'd0};
        vecs[27] = '{1, 1, 0, 0, 1, 0, 32'h0,         1, 0, 32'h1C00_0000, 1, 0, 0, 0, 3'd0, 1, 2'd0};
        vecs[28] = '{1, 0, 0, 0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 3'd1, 1, 2'd0};

        do_reset();
        for (int i = 0; i < NV; i++) apply_vec(vecs[i], i);

        do_reset();
        random_phase(400);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one sram-like memory port between the instruction-fetch requester (read-only) and the data-access requester of the MEM stage (read/write with byte strobes).
- Arbitrates each address phase, locks the grant until the address is accepted, and records the owner of every outstanding transaction in an in-order ID FIFO.
- Routes each returning data_ok/rdata back to the requester that issued it.
- Sits between the core pipeline and the SRAM/AXI bridge.

Parameters:
OUTSTANDING, 2, max accepted-but-not-returned transactions (FIFO depth, 1..4)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
inst_req  in  1  fetch request (read)
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch address accepted
inst_data_ok  out  1  fetch data returned
inst_rdata  out  32  fetch read data
data_req  in  1  data request
data_wr  in  1  1=write
data_size  in  2  0=byte,1=half,2=word
data_addr  in  32  data address
data_wstrb  in  4  write byte strobes
data_wdata  in  32  write data
data_addr_ok  out  1  data address accepted
data_data_ok  out  1  data read returned / write acknowledged
data_rdata  out  32  data read data
mem_req  out  1  downstream request
mem_wr  out  1  downstream write
mem_size  out  2  downstream size
mem_addr  out  32  downstream address
mem_wstrb  out  4  downstream strobes
mem_wdata  out  32  downstream write data
mem_addr_ok  in  1  downstream address accepted
mem_data_ok  in  1  downstream data/ack valid
mem_rdata  in  32  downstream read data
outstanding_cnt  out  3  current FIFO occupancy
proto_err  out  1  sticky: mem_data_ok received with FIFO empty

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, FIFO empty, outstanding_cnt=0, proto_err=0. Outputs during reset: all *_addr_ok, *_data_ok and mem_req = 0. Reset mid-transaction drops all in-flight IDs. Late mem_data_ok arriving after reset sets proto_err.
- Upstream rule: each requester holds req and its payload stable from assertion until its addr_ok.
- States:
  - IDLE: no grant held.
  - LOCK_I: fetch owns the port, address not yet accepted.
  - LOCK_D: data owns the port, address not yet accepted.
- full = (outstanding_cnt == OUTSTANDING).
- IDLE:
  - If full, mem_req=0 and no grant.
  - Otherwise: winner = data if data_req, else inst if inst_req. Data has fixed priority.
  - mem_req=1 and mem_* are driven from the winner combinationally (zero-cycle pass-through).
  - If mem_addr_ok the same cycle, the winner's addr_ok=1 and state stays IDLE. Otherwise go to LOCK_I or LOCK_D.
- LOCK_x:
  - mem_req=1 with x's payload, regardless of the other requester.
  - On mem_addr_ok: x_addr_ok=1, state->IDLE.
  - A fetch locked in LOCK_I is never preempted by a later data_req.
- Fetch payload on the port: mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0.
- The loser's addr_ok stays 0 in every cycle.
- Accept (mem_req & mem_addr_ok) pushes the owner ID (0=inst, 1=data) into the FIFO. Full is checked before grant, so no push ever occurs when full.
- mem_data_ok:
  - If the FIFO is non-empty, pop the head. head=0 drives inst_data_ok=1; head=1 drives data_data_ok=1. Both are combinational in the same cycle.
  - mem_rdata is fanned out to both *_rdata unconditionally. Consumers qualify with data_ok.
  - If the FIFO is empty: ignore, set proto_err=1.
- Push and pop in the same cycle: occupancy unchanged and order preserved. The FIFO is circular, with pointers wrapping mod OUTSTANDING.
- Pop in a cycle where full: the FIFO is no longer full from the next cycle. The grant decision in the current cycle still uses the registered full, which adds a one-cycle bubble by design.
- Writes also receive mem_data_ok and pop the FIFO like reads.
- outstanding_cnt is a registered occupancy value, 0..OUTSTANDING.

Test Plan:
- Fetch only: inst_req=1, addr=0x1C000000, mem_addr_ok=1 immediately, mem_data_ok 2 cycles later with rdata=0x02800000 -> inst_addr_ok same cycle; inst_data_ok=1, inst_rdata=0x02800000; data_data_ok=0; cnt 0->1->0.
- Conflict: inst_req and data_req (wr=1, addr=0x1000, wstrb=4'b0011, wdata=0xABCD1234) both rise, mem_addr_ok=1 -> data granted first (mem_wr=1, mem_wstrb=0011), fetch granted next cycle; data_ok order: data then inst.
- Lock: inst_req alone, mem_addr_ok held 0 for 3 cycles, data_req rises in cycle 1 -> mem_addr stays the fetch address all 3 cycles (LOCK_I); data_addr_ok=0 until the fetch is accepted.
- Full (OUTSTANDING=2): two accepted reads, no data_ok -> mem_req=0 with data_req=1 pending. Single mem_data_ok -> pops inst/data correctly; next cycle mem_req=1 again.
- Simultaneous push/pop: cnt=1, accept a new data read and return the head in the same cycle -> cnt stays 1, returned ID routed correctly, new ID queued behind.
- Reset mid-operation: cnt=2, resetn=0 one cycle -> cnt=0, state IDLE, outputs 0. Subsequent stray mem_data_ok -> proto_err=1, no *_data_ok asserted.
